// File: rtl/seq_generator.sv
// Command-driven rising/falling/equal sample generator feeding the 4-bit sequence detector.
// Optional macro SEQ_GEN_ERR_INJ_EN adds ERR_INJ to corrupt bit 0 of a single emitted sample.
module seq_generator #(
    parameter int unsigned DW    = 4,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned GAP_W = 2
) (
    input  logic             SYSCLK,
    input  logic             RST_B,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_MODE,
    input  logic [DW-1:0]    CMD_START,
    input  logic [LEN_W-1:0] CMD_LEN,
    input  logic [GAP_W-1:0] CMD_GAP,
    input  logic             HOLD,
`ifdef SEQ_GEN_ERR_INJ_EN
    input  logic             ERR_INJ,
`endif
    output logic             OUT_VALID,
    output logic [1:0]       OUT_MODE,
    output logic [DW-1:0]    OUT_DATA,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [DW-1:0]      r_cur;
    logic [LEN_W-1:0]   r_rem;
    logic [GAP_W-1:0]   r_gapld;
    logic [GAP_W-1:0]   r_gapcnt;
    logic               r_valid;
    logic [1:0]         r_mode;
    logic [DW-1:0]      r_data;
    logic               r_busy;
    logic               r_done;
    logic               r_ready;

    state_t             w_state;
    logic [DW-1:0]      w_cur;
    logic [LEN_W-1:0]   w_rem;
    logic [GAP_W-1:0]   w_gapld;
    logic [GAP_W-1:0]   w_gapcnt;
    logic               w_valid;
    logic [1:0]         w_mode;
    logic [DW-1:0]      w_data;
    logic [DW-1:0]      w_cur_step;
    logic               w_err_inj;

`ifdef SEQ_GEN_ERR_INJ_EN
    assign w_err_inj = ERR_INJ;
`else
    assign w_err_inj = 1'b0;
`endif

    // Per-mode advance of the current value; modes 10 and 11 hold it
    always_comb begin
        w_cur_step = r_cur;
        case (r_mode)
            2'b00:   w_cur_step = r_cur + DW'(1);
            2'b01:   w_cur_step = r_cur - DW'(1);
            default: w_cur_step = r_cur;
        endcase
    end

    // Next-state and datapath updates
    always_comb begin
        w_state  = r_state;
        w_cur    = r_cur;
        w_rem    = r_rem;
        w_gapld  = r_gapld;
        w_gapcnt = r_gapcnt;
        w_valid  = 1'b0;
        w_mode   = r_mode;
        w_data   = r_data;
        case (r_state)
            S_IDLE: begin
                if (CMD_VALID && r_ready) begin
                    w_cur   = CMD_START;
                    w_rem   = CMD_LEN;
                    w_gapld = CMD_GAP;
                    w_mode  = CMD_MODE;
                    w_state = (CMD_LEN == '0) ? S_DONE : S_EMIT;
                end
            end
            S_EMIT: begin
                if (!HOLD) begin
                    w_valid = 1'b1;
                    w_data  = r_cur ^ DW'(w_err_inj);
                    w_cur   = w_cur_step;
                    w_rem   = r_rem - LEN_W'(1);
                    if (r_rem == LEN_W'(1)) begin
                        w_state = S_DONE;
                    end else if (r_gapld != '0) begin
                        w_state  = S_GAP;
                        w_gapcnt = r_gapld;
                    end
                end
            end
            S_GAP: begin
                if (!HOLD) begin
                    w_gapcnt = r_gapcnt - GAP_W'(1);
                    if (r_gapcnt == GAP_W'(1)) begin
                        w_state = S_EMIT;
                    end
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State register; status flags are registered decodes of the next state
    always_ff @(posedge SYSCLK or negedge RST_B) begin
        if (!RST_B) begin
            r_state  <= S_IDLE;
            r_cur    <= '0;
            r_rem    <= '0;
            r_gapld  <= '0;
            r_gapcnt <= '0;
            r_valid  <= 1'b0;
            r_mode   <= 2'b11;
            r_data   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state;
            r_cur    <= w_cur;
            r_rem    <= w_rem;
            r_gapld  <= w_gapld;
            r_gapcnt <= w_gapcnt;
            r_valid  <= w_valid;
            r_mode   <= w_mode;
            r_data   <= w_data;
            r_busy   <= (w_state != S_IDLE);
            r_done   <= (w_state == S_DONE);
            r_ready  <= (w_state == S_IDLE);
        end
    end

    assign CMD_READY = r_ready;
    assign OUT_VALID = r_valid;
    assign OUT_MODE  = r_mode;
    assign OUT_DATA  = r_data;
    assign BUSY      = r_busy;
    assign DONE      = r_done;

endmodule

// File: doc/seq_generator.md
Name: seq_generator

Overview:
- Stimulus-side counterpart to the team's 4-bit sequence detector.
- Takes one command at a time: mode, start value, length and inter-sample gap.
- Emits a strobed stream of OUT_VALID/OUT_MODE/OUT_DATA that is rising (+1), falling (-1) or equal, and wire-compatible with the detector's IN_VALID/MODE/DATA_IN inputs.
- Used in block-level benches and in the on-chip self-test path ahead of the detector.

Parameters:
DW, 4, sample data width; arithmetic is modulo 2^DW
LEN_W, 4, width of CMD_LEN (max run length 2^LEN_W-1)
GAP_W, 2, width of CMD_GAP (idle cycles between samples)

Ports:
SYSCLK  input  1  clock, all state on rising edge
RST_B  input  1  asynchronous active-low reset
CMD_VALID  input  1  command request
CMD_READY  output  1  high only in IDLE; handshake = CMD_VALID & CMD_READY at a SYSCLK edge
CMD_MODE  input  2  00 rising, 01 falling, 10 equal, 11 null mode (detector ignores)
CMD_START  input  DW  first sample value
CMD_LEN  input  LEN_W  number of samples to emit
CMD_GAP  input  GAP_W  OUT_VALID-low cycles inserted between consecutive samples
HOLD  input  1  stall; freezes sequence progress
OUT_VALID  output  1  registered sample strobe (to detector IN_VALID)
OUT_MODE  output  2  registered mode (to detector MODE)
OUT_DATA  output  DW  registered sample (to detector DATA_IN)
BUSY  output  1  state != IDLE
DONE  output  1  one-cycle pulse: state == DONE

Behaviour:
- Reset (async, any state): state=IDLE, OUT_VALID=0, OUT_MODE=2'b11, OUT_DATA=0, DONE=0, BUSY=0, CMD_READY=1. Internal CUR, REM, GAPCNT cleared. A run in progress is abandoned with no DONE pulse.
- FSM states: IDLE, EMIT, GAP, DONE.
- IDLE, on handshake edge:
  - Latch CUR<=CMD_START, REM<=CMD_LEN, GAPLD<=CMD_GAP, OUT_MODE<=CMD_MODE.
  - If CMD_LEN==0, go to DONE. Otherwise go to EMIT.
  - CMD_* are ignored whenever CMD_READY=0.
- EMIT edge with HOLD=1: OUT_VALID<=0; nothing else changes.
- EMIT edge with HOLD=0:
  - OUT_VALID<=1, OUT_DATA<=CUR.
  - CUR advances: +1 (mode 00), -1 (mode 01), unchanged (modes 10 and 11). Wraps modulo 2^DW: F+1=0, 0-1=F.
  - REM<=REM-1.
  - If REM==1, go to DONE. Else if GAPLD!=0, go to GAP with GAPCNT<=GAPLD. Else stay in EMIT (back-to-back samples).
- GAP edge: OUT_VALID<=0. If HOLD=0, GAPCNT decrements, and at GAPCNT==1 go to EMIT. HOLD=1 freezes GAPCNT.
- DONE: lasts exactly one cycle, is not affected by HOLD, then goes to IDLE with OUT_VALID<=0 at that edge.
  - DONE is high during the cycle in which the final sample is visible (it coincides with the last OUT_VALID).
  - For CMD_LEN==0, DONE is high with OUT_VALID=0.
- Latency: handshake at edge k gives the first sample visible after edge k+1, assuming HOLD=0.
- Between commands there are at least 2 OUT_VALID-low cycles: one IDLE cycle plus the first EMIT cycle.
- OUT_MODE and OUT_DATA hold their values while OUT_VALID=0. OUT_MODE changes only at a handshake, so a same-mode continuation is seen downstream as one run.
- The sample count emitted equals CMD_LEN exactly, regardless of HOLD pattern.

Optional Feature:
- Macro SEQ_GEN_ERR_INJ_EN.
- When defined:
  - Adds input ERR_INJ (1 bit).
  - On an EMIT/HOLD=0 edge with ERR_INJ=1, OUT_DATA<=CUR^1 (bit 0 flipped).
  - CUR, REM and FSM progress exactly as without injection, so only that one sample is corrupted.
- When undefined: the port does not exist and behaviour is as above.

Test Plan:
- Rising, START=4'hE, LEN=5, GAP=0 -> OUT_DATA E,F,0,1,2 on 5 consecutive OUT_VALID cycles, DONE with the 2. A downstream detector flags 1 and 2.
- Falling, START=3, LEN=4, GAP=2 -> OUT_VALID high every 3rd cycle with 3,2,1,0; OUT_DATA holds in between; DONE with 0.
- Equal, START=7, LEN=3, HOLD=1 for 2 cycles after the first sample -> 7, two OUT_VALID=0 cycles, 7, 7. Exactly 3 samples, DONE on the last.
- LEN=0 -> no OUT_VALID; DONE=1 and CMD_READY=0 for the one cycle after the handshake, then CMD_READY=1.
- CMD_VALID held high across two rising commands (START 0 then 4, LEN=3) -> 0,1,2, DONE, two OUT_VALID-low cycles, then 4,5,6. The second command is accepted only in IDLE.
- RST_B low mid-run after 2 samples -> all outputs at reset values immediately, no DONE. After release the next command starts cleanly; with SEQ_GEN_ERR_INJ_EN, ERR_INJ on sample 2 of rising 0..3 -> 0,0,2,3.
